bram_portb_arbiter: RTL

BRAM_PORTB_ARBITER -- requirements
Module: bram_portb_arbiter

---
 rtl/bram_portb_arbiter_if.sv | 46 ++++
 rtl/bram_portb_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bram_portb_arbiter_if.sv
// Requester and BRAM port-B signal bundle for bram_portb_arbiter.
// slave = arbiter side; master = requesters plus the BRAM itself.
interface bram_portb_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) ();
    logic              req_valid_0;
    logic              req_ready_0;
    logic              req_we_0;
    logic [ADDR_W-1:0] req_addr_0;
    logic [DATA_W-1:0] req_wdata_0;
    logic              rsp_valid_0;
    logic [DATA_W-1:0] rsp_rdata_0;

    logic              req_valid_1;
    logic              req_ready_1;
    logic              req_we_1;
    logic [ADDR_W-1:0] req_addr_1;
    logic [DATA_W-1:0] req_wdata_1;
    logic              rsp_valid_1;
    logic [DATA_W-1:0] rsp_rdata_1;

    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;

    modport slave (
        input  req_valid_0, req_we_0, req_addr_0, req_wdata_0,
               req_valid_1, req_we_1, req_addr_1, req_wdata_1,
               bram_dout,
        output req_ready_0, rsp_valid_0, rsp_rdata_0,
               req_ready_1, rsp_valid_1, rsp_rdata_1,
               bram_en, bram_we, bram_addr, bram_din
    );

    modport master (
        output req_valid_0, req_we_0, req_addr_0, req_wdata_0,
               req_valid_1, req_we_1, req_addr_1, req_wdata_1,
               bram_dout,
        input  req_ready_0, rsp_valid_0, rsp_rdata_0,
               req_ready_1, rsp_valid_1, rsp_rdata_1,
               bram_en, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/bram_portb_arbiter.sv
// Two-requester round-robin arbiter for BRAM port B; clears the whole BRAM after reset.
// BRAM command 1 cycle after handshake, read data 3 cycles after; one transfer per cycle.
module bram_portb_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_done,
    bram_portb_arbiter_if.slave bus
);
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
    logic              clear_done_q, clear_done_d;
    logic              init_done_q, init_done_d;
    logic              ptr_q, ptr_d;

    logic              bram_en_q, bram_en_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0] bram_din_q, bram_din_d;

    logic              p1_rd_q, p1_rd_d;
    logic              p1_id_q, p1_id_d;
    logic              p2_rd_q, p2_rd_d;
    logic              p2_id_q, p2_id_d;

    logic              rsp_valid_0_q, rsp_valid_0_d;
    logic              rsp_valid_1_q, rsp_valid_1_d;
    logic [DATA_W-1:0] rsp_rdata_0_q, rsp_rdata_0_d;
    logic [DATA_W-1:0] rsp_rdata_1_q, rsp_rdata_1_d;

    logic              grant_0;
    logic              grant_1;
    logic              xfer;
    logic              xfer_we;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_wdata;

    // ptr_q == 0 favours requester 0 when both are valid.
    always_comb begin : arbitrate
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (!rst && state_q == ST_RUN) begin
            grant_0 = bus.req_valid_0 && (!bus.req_valid_1 || !ptr_q);
            grant_1 = bus.req_valid_1 && (!bus.req_valid_0 ||  ptr_q);
        end
    end

    assign xfer       = grant_0 || grant_1;
    assign xfer_we    = grant_1 ? bus.req_we_1    : bus.req_we_0;
    assign xfer_addr  = grant_1 ? bus.req_addr_1  : bus.req_addr_0;
    assign xfer_wdata = grant_1 ? bus.req_wdata_1 : bus.req_wdata_0;

    always_comb begin : next_state
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        clear_done_d = clear_done_q;
        init_done_d  = init_done_q;
        ptr_d        = ptr_q;
        bram_en_d    = 1'b0;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_din_d   = bram_din_q;
        p1_rd_d      = 1'b0;
        p1_id_d      = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                // clear_done_q marks the cycle the last address is on the bus.
                if (!clear_done_q) begin
                    bram_en_d   = 1'b1;
                    bram_we_d   = 1'b1;
                    bram_addr_d = clear_addr_q;
                    bram_din_d  = '0;
                    if (clear_addr_q == LAST_ADDR) begin
                        clear_done_d = 1'b1;
                    end else begin
                        clear_addr_d = clear_addr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    bram_en_d   = 1'b1;
                    bram_we_d   = xfer_we;
                    bram_addr_d = xfer_addr;
                    bram_din_d  = xfer_wdata;
                    p1_rd_d     = !xfer_we;
                    p1_id_d     = grant_1;
                    ptr_d       = grant_0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // p1 lines up with the BRAM command cycle, p2 with the BRAM data cycle.
    always_comb begin : response_path
        p2_rd_d       = p1_rd_q;
        p2_id_d       = p1_id_q;
        rsp_valid_0_d = p2_rd_q && !p2_id_q;
        rsp_valid_1_d = p2_rd_q &&  p2_id_q;
        rsp_rdata_0_d = rsp_valid_0_d ? bus.bram_dout : rsp_rdata_0_q;
        rsp_rdata_1_d = rsp_valid_1_d ? bus.bram_dout : rsp_rdata_1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_CLEAR;
            clear_addr_q  <= '0;
            clear_done_q  <= 1'b0;
            init_done_q   <= 1'b0;
            ptr_q         <= 1'b0;
            bram_en_q     <= 1'b0;
            bram_we_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_din_q    <= '0;
            p1_rd_q       <= 1'b0;
            p1_id_q       <= 1'b0;
            p2_rd_q       <= 1'b0;
            p2_id_q       <= 1'b0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            rsp_rdata_0_q <= '0;
            rsp_rdata_1_q <= '0;
        end else begin
            state_q       <= state_d;
            clear_addr_q  <= clear_addr_d;
            clear_done_q  <= clear_done_d;
            init_done_q   <= init_done_d;
            ptr_q         <= ptr_d;
            bram_en_q     <= bram_en_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            p1_rd_q       <= p1_rd_d;
            p1_id_q       <= p1_id_d;
            p2_rd_q       <= p2_rd_d;
            p2_id_q       <= p2_id_d;
            rsp_valid_0_q <= rsp_valid_0_d;
            rsp_valid_1_q <= rsp_valid_1_d;
            rsp_rdata_0_q <= rsp_rdata_0_d;
            rsp_rdata_1_q <= rsp_rdata_1_d;
        end
    end

    assign init_done       = init_done_q;
    assign bus.req_ready_0 = grant_0;
    assign bus.req_ready_1 = grant_1;
    assign bus.rsp_valid_0 = rsp_valid_0_q;
    assign bus.rsp_valid_1 = rsp_valid_1_q;
    assign bus.rsp_rdata_0 = rsp_rdata_0_q;
    assign bus.rsp_rdata_1 = rsp_rdata_1_q;
    assign bus.bram_en     = bram_en_q;
    assign bus.bram_we     = bram_we_q;
    assign bus.bram_addr   = bram_addr_q;
    assign bus.bram_din    = bram_din_q;
endmodule
